xilinx_arith_sequencer: RTL and testbench
=========================================

XILINX_ARITH_SEQUENCER -- requirements
Module: xilinx_arith_sequencer

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter LATENCY, default 6, expected core latency: cycles of continuous ce before core_valid.
REQ-003 Parameter TIMEOUT, default 15, maximum ce-high cycles to wait for core_valid before aborting.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair on in_a/in_b is offered.
REQ-007 in_ready  output  1  sequencer accepts an operand pair this cycle.
REQ-008 in_a  input  WIDTH  minuend operand.
REQ-009 in_b  input  WIDTH  subtrahend operand.
REQ-010 core_ce  output  1  clock enable to the pipelined core wrapper.
REQ-011 core_a  output  WIDTH  registered operand A to the core.
REQ-012 core_b  output  WIDTH  registered operand B to the core.
REQ-013 core_valid  input  1  one-cycle result-valid pulse from the core wrapper.
REQ-014 core_s  input  WIDTH  core result, sampled only when core_valid is high.
REQ-015 out_valid  output  1  captured result is presented.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_s  output  WIDTH  captured result.
REQ-018 out_err  output  1  qualifies out_s; high means timeout, out_s = 0.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, RUN, HOLD, GAP.
REQ-021 IDLE: in_ready = 1; on in_valid the pair SHALL be registered into core_a/core_b, the cycle counter cleared, and the FSM SHALL enter RUN.
REQ-022 RUN: core_ce SHALL be 1 every cycle; in_ready = 0; the counter SHALL increment each RUN cycle, saturating at TIMEOUT.
REQ-023 RUN: on core_valid, core_s SHALL be captured into out_s, out_err cleared, and the FSM SHALL enter HOLD the next cycle.
REQ-024 RUN: if the counter reaches TIMEOUT without core_valid, out_s SHALL be 0, out_err 1, and the FSM SHALL enter HOLD.
REQ-025 core_valid outside RUN SHALL be ignored.
REQ-026 HOLD: core_ce = 0; out_valid = 1; out_s/out_err SHALL be stable until the handshake; on out_valid & out_ready the FSM SHALL enter GAP.
REQ-027 GAP: exactly one cycle, core_ce = 0, in_ready = 0, then IDLE; this guarantees the core wrapper's valid shift register is cleared before the next operation.
REQ-028 Latency: for a nominal core, out_valid SHALL rise LATENCY+1 cycles after the in_valid & in_ready cycle.
REQ-029 Throughput: at most one operation per LATENCY+3 cycles; no overlapping operations.
REQ-030 core_ce SHALL never be high outside RUN.
REQ-031 Arithmetic is performed entirely by the core; the sequencer SHALL pass operands and result bit-exact, with no sign or width manipulation.

Reset
REQ-032 On resetn low, asynchronously: state IDLE, core_ce 0, out_valid 0, out_err 0, out_s 0, core_a 0, core_b 0, counter 0, busy 0.
REQ-033 Reset asserted mid-RUN SHALL drop core_ce immediately, discard the operation, and produce no out_valid after release.
REQ-034 in_ready SHALL be 0 while resetn is low and 1 in the first cycle after release.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the default WIDTH/LATENCY/TIMEOUT constants.
REQ-036 The block SHALL be a single module; the core wrapper is instantiated by the parent, not inside this module.

Verification
REQ-037 In IDLE, in_a=10, in_b=3 with a 6-cycle core model -> core_ce high for 6 cycles, out_s=7, out_err=0, out_valid 7 cycles after accept.
REQ-038 in_a=0, in_b=1 -> out_s=0xFFFF_FFFF_FFFF_FFFF (bit-exact signed -1).
REQ-039 Core model never asserts core_valid -> core_ce high for 15 cycles, then out_valid=1, out_err=1, out_s=0.
REQ-040 out_ready held 0 for 5 cycles in HOLD -> out_s stable, core_ce 0, in_ready 0; after accept, one GAP cycle, then in_ready=1.
REQ-041 resetn pulsed low at RUN cycle 3 -> core_ce 0 immediately, no out_valid afterwards, in_ready=1 after release.
REQ-042 Back-to-back in_valid held high with out_ready tied 1 -> accepts spaced LATENCY+3 = 9 cycles, core_ce low for at least 1 cycle between operations.

Source files
------------

// File: rtl/xilinx_arith_sequencer_pkg.sv
// xilinx_arith_sequencer_pkg: shared FSM state encoding and default sizing for the arithmetic sequencer
package xilinx_arith_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, GAP} state_t;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_LATENCY = 6;
  localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/xilinx_arith_sequencer.sv
// xilinx_arith_sequencer: one-at-a-time sequencer driving a clock-enabled pipelined core with timeout
//   in_valid/in_ready/in_a/in_b       operand pair handshake
//   core_ce/core_a/core_b             enable and registered operands to the core wrapper
//   core_valid/core_s                 result pulse and value from the core wrapper
//   out_valid/out_ready/out_s/out_err result handshake; out_err flags a timeout (out_s = 0)
//   busy                              high whenever not IDLE
module xilinx_arith_sequencer
  import xilinx_arith_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_ce,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_valid,
  input  logic [WIDTH-1:0] core_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_err,
  output logic             busy
);
  // counter is sized to cover the larger of the two so a misconfigured TIMEOUT < LATENCY still counts sanely
  localparam int CW = $clog2((TIMEOUT > LATENCY ? TIMEOUT : LATENCY) + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  state_t state;
  logic [CW-1:0] cnt;
  // decoded from state so the asynchronous reset drops core_ce immediately
  assign core_ce = state == RUN;
  assign out_valid = state == HOLD;
  assign busy = state != IDLE;
  assign in_ready = resetn && state == IDLE;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      core_a <= '0;
      core_b <= '0;
      out_s <= '0;
      out_err <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          core_a <= in_a;
          core_b <= in_b;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt == TO ? cnt : cnt + CW'(1);
          if (core_valid) begin
            out_s <= core_s;
            out_err <= 1'b0;
            state <= HOLD;
          end else if (cnt == TO - CW'(1)) begin
            // this RUN cycle brings the count to TIMEOUT: abort with a zero result
            out_s <= '0;
            out_err <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: if (out_ready) state <= GAP;
        GAP: state <= IDLE;
      endcase
endmodule

// File: tb/tb_xilinx_arith_sequencer.sv
// tb_xilinx_arith_sequencer: directed self-checking bench with a ce-gated core model
module tb_xilinx_arith_sequencer;
  localparam int W = 64;
  localparam int LAT = 6;
  localparam int TMO = 15;
  logic clk = 0, resetn = 0, in_valid = 0, out_ready = 1, model_en = 1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, core_ce, core_valid, out_valid, out_err, busy;
  logic [W-1:0] core_a, core_b, core_s, out_s;
  int cc;
  int checks = 0, failures = 0;
  xilinx_arith_sequencer #(.WIDTH(W), .LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_ce(core_ce), .core_a(core_a), .core_b(core_b),
    .core_valid(core_valid), .core_s(core_s), .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_err(out_err), .busy(busy)
  );
  always #5 clk = ~clk;
  // core model: result valid during the LAT-th consecutive ce cycle, cleared whenever ce drops
  always @(posedge clk or negedge resetn)
    if (!resetn) cc <= 0;
    else cc <= core_ce ? cc + 1 : 0;
  assign core_valid = model_en && core_ce && cc == LAT - 1;
  assign core_s = core_a - core_b;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  // called at a negedge in IDLE; returns ce-high cycles and the cycle out_valid was first seen (0 = never)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int ce_n, output int lat);
    in_valid = 1; in_a = a; in_b = b;
    chk("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    ce_n = 0; lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (core_ce) ce_n++;
      if (out_valid) lat = i;
      else @(negedge clk);
    end
  endtask
  int ce_n, lat, seen, n, lows;
  int acc[4];
  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_ce", core_ce, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_core_b", core_b, 0);
    @(negedge clk); @(negedge clk);
    resetn = 1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    run_op(64'd10, 64'd3, ce_n, lat);
    chk("sub_ce_cycles", ce_n, 6);
    chk("sub_latency", lat, 7);
    chk("sub_out_s", out_s, 64'd7);
    chk("sub_out_err", out_err, 0);
    @(negedge clk);
    chk("gap_in_ready", in_ready, 0);
    chk("gap_busy", busy, 1);
    chk("gap_out_valid", out_valid, 0);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    run_op(64'd0, 64'd1, ce_n, lat);
    chk("neg_out_s", out_s, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("neg_out_err", out_err, 0);
    @(negedge clk); @(negedge clk);
    model_en = 0;
    run_op(64'd5, 64'd2, ce_n, lat);
    chk("tmo_ce_cycles", ce_n, 15);
    chk("tmo_latency", lat, 16);
    chk("tmo_out_s", out_s, 0);
    chk("tmo_out_err", out_err, 1);
    model_en = 1;
    @(negedge clk); @(negedge clk);
    out_ready = 0;
    run_op(64'd20, 64'd5, ce_n, lat);
    chk("hold_latency", lat, 7);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_s", out_s, 64'd15);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_core_ce", core_ce, 0);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1;
    chk("hold_still_valid", out_valid, 1);
    @(negedge clk);
    chk("hold_gap_valid", out_valid, 0);
    chk("hold_gap_ready", in_ready, 0);
    @(negedge clk);
    chk("hold_idle_ready", in_ready, 1);
    in_valid = 1; in_a = 64'd9; in_b = 64'd4;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("mid_run_ce", core_ce, 1);
    resetn = 0;
    #1;
    chk("mid_rst_ce", core_ce, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    chk("mid_rel_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || core_ce) seen++;
      @(negedge clk);
    end
    chk("mid_no_activity", seen, 0);
    in_valid = 1; in_a = 64'd100; in_b = 64'd1;
    n = 0; lows = 0;
    for (int c = 0; c < 27; c++) begin
      if (in_valid && in_ready && n < 4) begin acc[n] = c; n++; end
      if (n == 1 && c > 0 && !core_ce) lows++;
      @(negedge clk);
    end
    in_valid = 0;
    chk("b2b_count", n, 3);
    chk("b2b_space1", acc[1] - acc[0], 9);
    chk("b2b_space2", acc[2] - acc[1], 9);
    chk("b2b_ce_low", lows, 2);
    chk("b2b_out_s", out_s, 64'd99);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
